// File: rtl/cache_ctrl_assoc_pkg.sv
// Shared types and helpers for the set-associative write-back cache controller.
// The field widths of the default configuration are also derived here.
package cache_ctrl_assoc_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } cache_state_e;

  localparam int unsigned DEF_ADDR_W     = 16;
  localparam int unsigned DEF_DATA_W     = 16;
  localparam int unsigned DEF_SETS       = 8;
  localparam int unsigned DEF_LINE_WORDS = 8;
  localparam int unsigned DEF_WAYS       = 2;

  localparam int unsigned DEF_OFFSET_W = $clog2(DEF_LINE_WORDS);
  localparam int unsigned DEF_INDEX_W  = $clog2(DEF_SETS);
  localparam int unsigned DEF_TAG_W    = DEF_ADDR_W - 1 - DEF_OFFSET_W - DEF_INDEX_W;

  typedef struct packed {
    logic [31:0] tag;
    logic [31:0] index;
    logic [31:0] offset;
  } addr_fields_t;

  // Byte address -> word offset, set index and tag; bit 0 is the byte lane.
  function automatic addr_fields_t split_addr(input logic [31:0] addr,
                                              input int unsigned ow,
                                              input int unsigned iw);
    addr_fields_t f;
    f.offset = (addr >> 1) & ((32'd1 << ow) - 32'd1);
    f.index  = (addr >> (1 + ow)) & ((32'd1 << iw) - 32'd1);
    f.tag    = addr >> (1 + ow + iw);
    return f;
  endfunction

endpackage

// File: rtl/cache_ctrl_assoc_way_array.sv
// Storage for one cache way: valid/dirty/tag per set plus the line data.
// Reads are asynchronous; all writes share one set index per cycle.
module cache_way_array
  import cache_ctrl_assoc_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned SETS       = DEF_SETS,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned TAG_W      = DEF_TAG_W,
  localparam int unsigned IW        = $clog2(SETS),
  localparam int unsigned OW        = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IW-1:0]     rd_idx,
  input  logic [OW-1:0]     rd_off,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic [IW-1:0]     wr_idx,
  input  logic [OW-1:0]     wr_off,
  input  logic              data_we,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              dirty_we,
  input  logic              dirty_val,
  input  logic              tag_we,
  input  logic [TAG_W-1:0]  tag_val
);

  logic [SETS-1:0]   valid_q, valid_d;
  logic [SETS-1:0]   dirty_q, dirty_d;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [TAG_W-1:0]  tag_d  [SETS];
  logic [DATA_W-1:0] data_q [SETS][LINE_WORDS];
  logic [DATA_W-1:0] data_d [SETS][LINE_WORDS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx][rd_off];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (tag_we) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = tag_val;
    end
    if (dirty_we) dirty_d[wr_idx] = dirty_val;
    if (data_we)  data_d[wr_idx][wr_off] = wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; valid=0 already
  // makes their contents meaningless, and resettable RAM-like arrays cost a lot.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/cache_ctrl_assoc.sv
// 1- or 2-way set-associative write-back, write-allocate cache controller.
// Misses stall the CPU, write back a dirty victim, refill the line, then replay as a hit.
module cache_ctrl_assoc
  import cache_ctrl_assoc_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned SETS       = DEF_SETS,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned WAYS       = DEF_WAYS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              write,
  input  logic [ADDR_W-1:0] address_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       miss_count
);

  localparam int unsigned OW = $clog2(LINE_WORDS);
  localparam int unsigned IW = $clog2(SETS);
  localparam int unsigned TW = ADDR_W - 1 - OW - IW;

  cache_state_e      state_q, state_d;
  logic [OW-1:0]     beat_q, beat_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [TW-1:0]     tag_q, tag_d;
  logic              victim_q, victim_d;
  logic [15:0]       miss_q, miss_d;
  logic [SETS-1:0]   lru_q, lru_d;

  addr_fields_t      fields;
  logic [TW-1:0]     req_tag;
  logic [IW-1:0]     req_idx;
  logic [OW-1:0]     req_off;

  always_comb begin
    fields  = split_addr(32'(address_in), OW, IW);
    req_tag = TW'(fields.tag);
    req_idx = IW'(fields.index);
    req_off = OW'(fields.offset);
  end

  logic [1:0]        way_valid, way_dirty, hit_vec;
  logic [TW-1:0]     way_tag  [2];
  logic [DATA_W-1:0] way_data [2];
  logic [1:0]        data_we, dirty_we, tag_we;
  logic              dirty_val;
  logic [IW-1:0]     rd_idx, wr_idx;
  logic [OW-1:0]     rd_off, wr_off;
  logic [DATA_W-1:0] wr_data;

  // While a miss is in flight every lookup targets the latched set and the current beat.
  assign rd_idx = (state_q == IDLE) ? req_idx : idx_q;
  assign rd_off = (state_q == IDLE) ? req_off : beat_q;

  for (genvar w = 0; w < 2; w++) begin : g_way
    if (w < WAYS) begin : g_inst
      cache_way_array #(
        .DATA_W     (DATA_W),
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TW)
      ) u_way (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (rd_idx),
        .rd_off    (rd_off),
        .rd_valid  (way_valid[w]),
        .rd_dirty  (way_dirty[w]),
        .rd_tag    (way_tag[w]),
        .rd_data   (way_data[w]),
        .wr_idx    (wr_idx),
        .wr_off    (wr_off),
        .data_we   (data_we[w]),
        .wr_data   (wr_data),
        .dirty_we  (dirty_we[w]),
        .dirty_val (dirty_val),
        .tag_we    (tag_we[w]),
        .tag_val   (tag_q)
      );
    end else begin : g_tie
      assign way_valid[w] = 1'b0;
      assign way_dirty[w] = 1'b0;
      assign way_tag[w]   = '0;
      assign way_data[w]  = '0;
    end
  end

  logic hit, hit_way, vic, last_beat;

  always_comb begin
    for (int w = 0; w < 2; w++) hit_vec[w] = way_valid[w] && (way_tag[w] == req_tag);
    hit     = req && (hit_vec != 2'b00);
    hit_way = hit_vec[1];
    // Invalid way first (way 0 preferred), otherwise the least recently used way.
    vic       = (WAYS == 2) && way_valid[0] && (!way_valid[1] || lru_q[req_idx]);
    last_beat = (beat_q == OW'(LINE_WORDS - 1));
  end

  // NOTE: every output and next-state variable gets a default first so that
  // no path through the case statement can leave one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    idx_d     = idx_q;
    tag_d     = tag_q;
    victim_d  = victim_q;
    miss_d    = miss_q;
    lru_d     = lru_q;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    data_out  = '0;
    data_we   = '0;
    dirty_we  = '0;
    tag_we    = '0;
    dirty_val = 1'b0;
    wr_idx    = idx_q;
    wr_off    = beat_q;
    wr_data   = mem_rdata;

    unique case (state_q)
      IDLE: begin
        if (hit) begin
          data_out              = way_data[hit_way];
          lru_d[req_idx]        = ~hit_way;
          if (write) begin
            data_we[hit_way]  = 1'b1;
            dirty_we[hit_way] = 1'b1;
            dirty_val         = 1'b1;
            wr_idx            = req_idx;
            wr_off            = req_off;
            wr_data           = data_in;
          end
        end else if (req) begin
          stall    = 1'b1;
          idx_d    = req_idx;
          tag_d    = req_tag;
          victim_d = vic;
          if (miss_q != 16'hFFFF) miss_d = miss_q + 16'd1;
          state_d  = (way_valid[vic] && way_dirty[vic]) ? WRITEBACK : FILL;
        end
      end

      WRITEBACK: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {way_tag[victim_q], idx_q, beat_q, 1'b0};
        mem_wdata = way_data[victim_q];
        if (mem_ready) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            dirty_we[victim_q] = 1'b1;
            state_d            = FILL;
          end
        end
      end

      FILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {tag_q, idx_q, beat_q, 1'b0};
        if (mem_ready) begin
          data_we[victim_q] = 1'b1;
          beat_d            = beat_q + 1'b1;
          if (last_beat) begin
            tag_we[victim_q]   = 1'b1;
            dirty_we[victim_q] = 1'b1;
            state_d            = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      idx_q    <= '0;
      tag_q    <= '0;
      victim_q <= 1'b0;
      miss_q   <= '0;
      lru_q    <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      idx_q    <= idx_d;
      tag_q    <= tag_d;
      victim_q <= victim_d;
      miss_q   <= miss_d;
      lru_q    <= lru_d;
    end
  end

  assign miss_count = miss_q;

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Self-checking bench for cache_ctrl_assoc: directed scenarios then random traffic,
// checked against an architectural memory image and a tag/LRU reference model.
module tb_cache_ctrl_assoc;

  logic        clk = 1'b0;
  logic        rst, req, write, stall, mem_req, mem_we, mem_ready;
  logic [15:0] address_in, data_in, data_out, mem_addr, mem_wdata, mem_rdata, miss_count;

  cache_ctrl_assoc dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .write      (write),
    .address_in (address_in),
    .data_in    (data_in),
    .data_out   (data_out),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
  } beat_t;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem_env [32768];
  logic [15:0] arch    [32768];
  bit          mvalid  [2][8];
  bit          mdirty  [2][8];
  logic [8:0]  mtag    [2][8];
  bit          mlru    [8];
  int          mmiss;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int s = 0; s < 8; s++) begin
      mlru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        mvalid[w][s] = 1'b0;
        mdirty[w][s] = 1'b0;
        mtag[w][s]   = '0;
      end
    end
    for (int i = 0; i < 32768; i++) arch[i] = mem_env[i];
    mmiss = 0;
  endtask

  task automatic idle_cycle();
    req       = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    #1;
    check("idle_stall", stall, 0);
    check("idle_mem_req", mem_req, 0);
    check("idle_data_out", data_out, 0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
  endtask

  // Runs one CPU access to completion acting as the memory; mode 0: ready always,
  // 1: ready pattern 1,0,0,1, 2: random ready. abort_fill>=0 resets after that many fill beats.
  task automatic access(input bit w, input logic [15:0] a, input logic [15:0] d,
                        input int mode, input int abort_fill);
    int         idx, hitw, vic, stall_cycles, fill_seen, cyc, exp_stall;
    logic [8:0] tg;
    beat_t      q[$];
    beat_t      b;
    bit         miss, done, prev_wait;
    logic [15:0] prev_addr;

    idx  = int'(a[6:4]);
    tg   = a[15:7];
    hitw = -1;
    vic  = 0;
    for (int wy = 0; wy < 2; wy++)
      if (mvalid[wy][idx] && mtag[wy][idx] == tg) hitw = wy;
    miss = (hitw < 0);
    if (miss) begin
      if (!mvalid[0][idx])      vic = 0;
      else if (!mvalid[1][idx]) vic = 1;
      else                      vic = int'(mlru[idx]);
      if (mvalid[vic][idx] && mdirty[vic][idx])
        for (int bb = 0; bb < 8; bb++) q.push_back('{1'b1, {mtag[vic][idx], 3'(idx), 3'(bb), 1'b0}});
      for (int bb = 0; bb < 8; bb++) q.push_back('{1'b0, {tg, 3'(idx), 3'(bb), 1'b0}});
      if (mmiss < 65535) mmiss++;
    end
    exp_stall = miss ? 1 + q.size() : 0;

    req = 1'b1; write = w; address_in = a; data_in = d;
    stall_cycles = 0; fill_seen = 0; cyc = 0; done = 1'b0; prev_wait = 1'b0; prev_addr = '0;

    while (!done) begin
      if (abort_fill >= 0 && fill_seen == abort_fill) begin
        rst = 1'b0;
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_miss_count", miss_count, 0);
        req = 1'b0;
        #1;
        check("rst_stall", stall, 0);
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        reset_model();
        return;
      end
      case (mode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: mem_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      mem_rdata = (mem_req && !mem_we) ? mem_env[mem_addr[15:1]] : 16'($urandom);
      #1;
      if (cyc == 0) check("stall_at_request", stall, 32'(miss));
      if (stall) begin
        stall_cycles++;
        if (prev_wait && mem_req) check("addr_held_in_wait", mem_addr, prev_addr);
        if (mem_req && mem_ready) begin
          if (q.size() == 0) begin
            check("unexpected_beat", mem_req, 0);
          end else begin
            b = q.pop_front();
            check("beat_we", mem_we, b.we);
            check("beat_addr", mem_addr, b.addr);
            if (mem_we) begin
              check("wb_data", mem_wdata, arch[b.addr[15:1]]);
              mem_env[mem_addr[15:1]] = mem_wdata;
            end else begin
              fill_seen++;
            end
          end
        end
        prev_wait = mem_req && !mem_ready;
        prev_addr = mem_addr;
      end else begin
        check("hit_no_mem_req", mem_req, 0);
        if (!w) check("load_data", data_out, arch[a[15:1]]);
        done = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (!done && cyc > 400) begin
        check("timeout_stall", stall, 0);
        done = 1'b1;
      end
    end

    req = 1'b0;
    mem_ready = 1'b0;
    if (miss) begin
      mvalid[vic][idx] = 1'b1;
      mtag[vic][idx]   = tg;
      mdirty[vic][idx] = 1'b0;
      hitw = vic;
    end
    mlru[idx] = (hitw == 0);
    if (w) begin
      arch[a[15:1]]     = d;
      mdirty[hitw][idx] = 1'b1;
    end
    check("beats_remaining", q.size(), 0);
    check("miss_count", miss_count, mmiss);
    if (mode == 0) check("stall_cycles", stall_cycles, exp_stall);
  endtask

  initial begin
    logic [15:0] ra;
    rst = 1'b0; req = 1'b0; write = 1'b0; address_in = '0; data_in = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 32768; i++) mem_env[i] = 16'($urandom);
    reset_model();

    #12;
    check("reset_stall", stall, 0);
    check("reset_mem_req", mem_req, 0);
    check("reset_mem_we", mem_we, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_mem_wdata", mem_wdata, 0);
    check("reset_miss_count", miss_count, 0);
    check("reset_data_out", data_out, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    access(1'b1, 16'h1234, 16'h5678, 0, -1);   // cold store: 9-cycle stall
    check("cold_store_misses", miss_count, 1);
    access(1'b0, 16'h1234, 16'h0000, 0, -1);   // load hit returns stored word
    access(1'b0, 16'h1236, 16'h0000, 0, -1);   // load hit returns filled word
    access(1'b1, 16'h12B4, 16'hBEEF, 0, -1);   // same set, second way
    access(1'b0, 16'h1234, 16'h0000, 0, -1);
    check("second_way_misses", miss_count, 2);
    access(1'b0, 16'h12B4, 16'h0000, 0, -1);   // make way 0 the LRU way
    access(1'b0, 16'h1334, 16'h0000, 0, -1);   // dirty eviction: 17-cycle stall
    access(1'b0, 16'h13B4, 16'h0000, 1, -1);   // wait states during writeback and fill
    access(1'b0, 16'h13B6, 16'h0000, 0, -1);
    idle_cycle();
    access(1'b0, 16'h1234, 16'h0000, 0, 3);    // reset during fill beat 3
    access(1'b0, 16'h1234, 16'h0000, 0, -1);
    check("miss_count_restart", miss_count, 1);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 5) == 0) idle_cycle();
      ra = {9'(9'h024 + $urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 1'b0};
      access(1'($urandom_range(0, 1)), ra, 16'($urandom), int'($urandom_range(0, 2)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_ctrl_assoc.md
Name: cache_ctrl_assoc

Overview:
Parametrised successor to the current direct-mapped cache controller: a 1- or 2-way set-associative, write-back, write-allocate cache for 16-bit words with byte addressing. Sits between the CPU memory stage and a multi-cycle word-wide memory. Stalls the CPU on a miss, writes back a dirty victim, fills the line one word per accepted beat, then completes the original access as a hit. Exports a saturating miss counter.

Parameters:
ADDR_W, 16, byte-address width
DATA_W, 16, word width
SETS, 8, number of sets (power of 2)
LINE_WORDS, 8, words per line (power of 2)
WAYS, 2, associativity; legal values 1 or 2 only

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req  in  1  CPU access valid
write  in  1  1=store, 0=load (qualified by req)
address_in  in  ADDR_W  byte address; bit 0 ignored
data_in  in  DATA_W  store data
data_out  out  DATA_W  load data; valid when req & ~stall
stall  out  1  CPU must hold req/write/address_in/data_in
mem_req  out  1  memory beat request
mem_we  out  1  1=write-back beat, 0=fill beat
mem_addr  out  ADDR_W  word-aligned beat address
mem_wdata  out  DATA_W  write-back data
mem_ready  in  1  beat accepted this cycle (reads: mem_rdata valid this cycle)
mem_rdata  in  DATA_W  fill data
miss_count  out  16  saturating miss counter

Behaviour:
- Address split: offset = address_in[OW:1], OW=log2(LINE_WORDS); index = next log2(SETS) bits; tag = remaining upper bits. Defaults: offset [3:1], index [6:4], tag [15:7].
- Per way/set state: valid, dirty, tag, LRU bit (per set, used only when WAYS=2); data array in flops, asynchronous read.
- Reset (rst=0, async): valid/dirty/LRU all 0, state IDLE, beat counter 0, miss_count 0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. data_out=0 while no hit. Reset mid-miss abandons the transfer immediately.
- FSM states: IDLE, WRITEBACK, FILL.
- IDLE: hit = req & valid & tag match in any way. On a hit: stall=0, data_out = hit word (combinational, same cycle). A store writes data_in at clk edge and sets dirty. LRU points to the non-hit way. On req & ~hit: stall=1 combinationally; latch index/tag; choose victim (invalid way first, way 0 preferred; else the LRU way); miss_count += 1, saturating at 0xFFFF. Next state is WRITEBACK if the victim is valid & dirty, else FILL.
- WRITEBACK: stall=1, mem_req=1, mem_we=1. mem_addr = {victim tag, index, beat, 0}. mem_wdata = victim word[beat]. Beat advances on mem_ready. After LRU... after LINE_WORDS beats: clear dirty, go to FILL.
- FILL: stall=1, mem_req=1, mem_we=0. mem_addr = {req tag, index, beat, 0}. On mem_ready, write mem_rdata into victim word[beat]. After the last beat, set valid=1, dirty=0, tag=req tag; go to IDLE. The held request then hits next cycle; a store merges there.
- Beat counter is log2(LINE_WORDS) bits, wraps to 0 at end of each phase. mem_ready low inserts wait cycles with all outputs held.
- Miss latency with mem_ready tied high: clean miss = stall for 1+LINE_WORDS cycles; dirty miss = 1+2*LINE_WORDS cycles.
- req=0 in IDLE: stall=0, no state change. Inputs changing during stall are a CPU protocol violation. The controller uses the latched index/tag until it returns to IDLE.
- WAYS=1: LRU unused, victim is always way 0.

Decomposition:
- Shared package: cache state enum (IDLE/WRITEBACK/FILL), field-width localparams derived from the parameters, and a function extracting tag, index and offset.
- One natural sub-module: cache_way_array (tag/valid/dirty/data storage for one way, async read, sync write), instantiated WAYS times.

Test Plan:
- Cold store: reset, req=1 write=1 addr 0x1234 data 0x5678, mem_ready=1 -> stall 9 cycles; 8 fill reads at 0x1230..0x123E; then stall=0; miss_count=1.
- Load hit: load 0x1234 -> data_out=0x5678, stall=0 same cycle, no mem_req; a load of 0x1236 returns the filled memory word.
- Second way: store 0x12B4 (index 3, tag 0x25) -> fills way 1; then load 0x1234 still hits; miss_count=2.
- Dirty eviction: touch 0x12B4, then load 0x1334 -> 8 write beats of line 0x1230 (including 0x5678 at 0x1234), then 8 fill beats; stall 17 cycles.
- Wait states: mem_ready toggling 1,0,0,1… during fill -> beat advances only on mem_ready; mem_addr held while mem_ready=0; final data correct.
- Reset mid-fill: drop rst at beat 3 -> mem_req=0 immediately; then load 0x1234 misses again; miss_count restarts at 1.
